// File: rtl/rv32_pkg.sv
// Shared RV32 core types: FSM state encoding, datapath width and reset PC.
// Pure definitions; no logic, no latency, no flow control.
package rv32_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_t;
endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Next-PC priority mux (jalr > jal > taken branch > sequential) with misalign flag.
// Purely combinational, zero latency; no flow control.
module next_pc_sel
    import rv32_pkg::*;
(
    input  logic            jalr,
    input  logic            jal,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] sb_target,
    input  logic [XLEN-1:0] uj_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] seq_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);
    always_comb begin
        next_pc = seq_target;
        if (jalr) begin
            next_pc    = jalr_target;
            next_pc[0] = 1'b0;
        end else if (jal) begin
            next_pc = uj_target;
        end else if (branch_taken) begin
            next_pc = sb_target;
        end
    end

    // Bit 0 is always zero for legal targets, so only bit 1 can misalign.
    assign misalign = next_pc[1];
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the PC, runs the imem handshake, retires one instruction at a time.
// Fetch waits on imem_ready (min 1 cycle); EXEC holds instr until instr_accept; TRAP is terminal until rst.
module pc_sequencer
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] INSTRET_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_accept,
    input  logic            branch_taken,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] sb_target,
    input  logic [XLEN-1:0] uj_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic            trap_misalign,
    output logic [XLEN-1:0] instret
);
    state_t          state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            misalign;
    logic            fetch_done;
    logic            retire;
    logic            trap_hit;

    assign pc_plus4 = instr_pc + 32'd4;

    next_pc_sel u_next_pc_sel (
        .jalr         (jalr),
        .jal          (jal),
        .branch_taken (branch_taken),
        .sb_target    (sb_target),
        .uj_target    (uj_target),
        .jalr_target  (jalr_target),
        .seq_target   (pc_plus4),
        .next_pc      (next_pc),
        .misalign     (misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_done  = 1'b0;
        retire      = 1'b0;
        trap_hit    = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetch_done = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (instr_accept) begin
                    if (misalign) begin
                        trap_hit  = 1'b1;
                        state_nxt = TRAP;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            TRAP:    state_nxt = TRAP;
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            instr         <= '0;
            instr_pc      <= '0;
            trap_misalign <= 1'b0;
            instret       <= INSTRET_INIT;
        end else begin
            if (fetch_done) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            if (retire) begin
                pc      <= next_pc;
                instret <= instret + 32'd1;
            end
            if (trap_hit) trap_misalign <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for fetch/exec sequences plus reset/wrap/trap corners.
// A second instance exercises PC and instret wraparound from preloaded reset values.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, instr_valid, trap_misalign;
    logic [31:0] imem_addr, instr, instr_pc, pc_plus4, instret;
    logic        imem_ready = 1'b0, instr_accept = 1'b0;
    logic        branch_taken = 1'b0, jal = 1'b0, jalr = 1'b0;
    logic [31:0] imem_rdata = '0, sb_target = '0, uj_target = '0, jalr_target = '0;

    logic        w_req, w_valid, w_trap, w_ready = 1'b0, w_accept = 1'b0;
    logic [31:0] w_addr, w_instr, w_ipc, w_p4, w_ret;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_accept(instr_accept),
        .branch_taken(branch_taken), .jal(jal), .jalr(jalr), .sb_target(sb_target),
        .uj_target(uj_target), .jalr_target(jalr_target), .pc_plus4(pc_plus4),
        .trap_misalign(trap_misalign), .instret(instret)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .INSTRET_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(w_ready), .imem_rdata(32'h0000_0013), .instr_valid(w_valid),
        .instr(w_instr), .instr_pc(w_ipc), .instr_accept(w_accept),
        .branch_taken(1'b0), .jal(1'b0), .jalr(1'b0), .sb_target(32'h0),
        .uj_target(32'h0), .jalr_target(32'h0), .pc_plus4(w_p4),
        .trap_misalign(w_trap), .instret(w_ret)
    );

    typedef struct {
        logic [31:0] pc;
        int          stall;
        logic        bt, j, jr;
        logic [31:0] sb, uj, jt;
        logic [31:0] exp_p4;
        logic [31:0] exp_next;
        logic        exp_trap;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        instr_accept = 1'b0; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
        sb_target = '0; uj_target = '0; jalr_target = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ready = 1'b0; w_ready = 1'b0; w_accept = 1'b0;
        clear_ctl();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Waits (bounded) for the request, stalls, then completes it with word.
    task automatic do_fetch(input logic [31:0] addr, input int stall, input logic [31:0] word);
        int waited = 0;
        while (!imem_req && waited < 10) begin
            tick();
            waited++;
        end
        chk("fetch_req", {31'b0, imem_req}, 32'h1);
        for (int s = 0; s < stall; s++) begin
            instr_accept = 1'b1; jal = 1'b1; uj_target = 32'h300;
            chk("stall_req", {31'b0, imem_req}, 32'h1);
            chk("stall_addr", imem_addr, addr);
            chk("stall_valid", {31'b0, instr_valid}, 32'h0);
            tick();
        end
        clear_ctl();
        chk("fetch_addr", imem_addr, addr);
        imem_ready = 1'b1; imem_rdata = word;
        tick();
        imem_ready = 1'b0; imem_rdata = '0;
        chk("exec_valid", {31'b0, instr_valid}, 32'h1);
        chk("exec_instr", instr, word);
        chk("exec_pc", instr_pc, addr);
        chk("exec_no_req", {31'b0, imem_req}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h00, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0,   32'h04, 32'h04,  1'b0, 32'd1};
        vecs[1] = '{32'h04, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0,   32'h08, 32'h08,  1'b0, 32'd2};
        vecs[2] = '{32'h08, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0,   32'h0C, 32'h0C,  1'b0, 32'd3};
        vecs[3] = '{32'h0C, 0, 0, 0, 0, 32'h0,  32'h0,   32'h0,   32'h10, 32'h10,  1'b0, 32'd4};
        vecs[4] = '{32'h10, 5, 0, 0, 0, 32'h0,  32'h0,   32'h0,   32'h14, 32'h14,  1'b0, 32'd5};
        vecs[5] = '{32'h14, 1, 1, 0, 0, 32'h20, 32'h0,   32'h0,   32'h18, 32'h20,  1'b0, 32'd6};
        vecs[6] = '{32'h20, 0, 1, 1, 0, 32'h40, 32'h100, 32'h0,   32'h24, 32'h100, 1'b0, 32'd7};
        vecs[7] = '{32'h100, 0, 1, 1, 1, 32'h40, 32'h80, 32'h203, 32'h104, 32'h100, 1'b1, 32'd7};

        rst = 1'b1;
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_trap", {31'b0, trap_misalign}, 32'h0);
        chk("rst_instret", instret, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_to_fetch", {31'b0, imem_req}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            do_fetch(vecs[i].pc, vecs[i].stall, 32'hA500_0000 | i);
            chk("pc_plus4", pc_plus4, vecs[i].exp_p4);
            branch_taken = vecs[i].bt; jal = vecs[i].j; jalr = vecs[i].jr;
            sb_target = vecs[i].sb; uj_target = vecs[i].uj; jalr_target = vecs[i].jt;
            instr_accept = 1'b1;
            tick();
            clear_ctl();
            chk("instret", instret, vecs[i].exp_ret);
            chk("trap", {31'b0, trap_misalign}, {31'b0, vecs[i].exp_trap});
            if (vecs[i].exp_trap) begin
                chk("trap_no_req", {31'b0, imem_req}, 32'h0);
                chk("trap_no_valid", {31'b0, instr_valid}, 32'h0);
                chk("trap_pc_held", imem_addr, vecs[i].exp_next);
            end else begin
                chk("next_req", {31'b0, imem_req}, 32'h1);
                chk("next_addr", imem_addr, vecs[i].exp_next);
            end
        end
        repeat (3) tick();
        chk("trap_sticky", {31'b0, trap_misalign}, 32'h1);
        chk("trap_still_no_req", {31'b0, imem_req}, 32'h0);

        // Reset while a fetch is pending, with a late imem_ready overlapping reset.
        do_reset();
        do_fetch(32'h0, 0, 32'h11);
        instr_accept = 1'b1;
        tick();
        clear_ctl();
        tick();
        #2 rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("midf_req", {31'b0, imem_req}, 32'h0);
        chk("midf_addr", imem_addr, 32'h0);
        chk("midf_instret", instret, 32'h0);
        chk("midf_ipc", instr_pc, 32'h0);
        tick();
        chk("midf_late_valid", {31'b0, instr_valid}, 32'h0);
        chk("midf_late_instr", instr, 32'h0);
        rst = 1'b0; imem_ready = 1'b0;
        tick();
        chk("midf_restart_req", {31'b0, imem_req}, 32'h1);
        chk("midf_restart_addr", imem_addr, 32'h0);
        chk("midf_restart_valid", {31'b0, instr_valid}, 32'h0);

        // Reset while in EXEC.
        do_fetch(32'h0, 0, 32'h22);
        instr_accept = 1'b1;
        tick();
        clear_ctl();
        do_fetch(32'h4, 0, 32'h33);
        #2 rst = 1'b1;
        #1;
        chk("mide_valid", {31'b0, instr_valid}, 32'h0);
        chk("mide_instr", instr, 32'h0);
        chk("mide_ipc", instr_pc, 32'h0);
        chk("mide_addr", imem_addr, 32'h0);
        chk("mide_instret", instret, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("mide_restart_addr", imem_addr, 32'h0);

        // Misaligned taken branch.
        do_fetch(32'h0, 0, 32'h44);
        instr_accept = 1'b1;
        tick();
        clear_ctl();
        do_fetch(32'h4, 0, 32'h55);
        branch_taken = 1'b1; sb_target = 32'h32; instr_accept = 1'b1;
        tick();
        clear_ctl();
        chk("mis_trap", {31'b0, trap_misalign}, 32'h1);
        chk("mis_instret", instret, 32'h1);
        chk("mis_no_req", {31'b0, imem_req}, 32'h0);
        repeat (4) tick();
        chk("mis_sticky", {31'b0, trap_misalign}, 32'h1);
        chk("mis_instret_held", instret, 32'h1);

        // PC and instret wraparound on the preloaded instance.
        do_reset();
        chk("wrap_rst_trap", {31'b0, trap_misalign}, 32'h0);
        chk("wrap_req", {31'b0, w_req}, 32'h1);
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        chk("wrap_valid", {31'b0, w_valid}, 32'h1);
        chk("wrap_p4", w_p4, 32'h0);
        chk("wrap_ret_init", w_ret, 32'hFFFF_FFFF);
        w_accept = 1'b1;
        tick();
        w_accept = 1'b0;
        chk("wrap_next_addr", w_addr, 32'h0);
        chk("wrap_next_req", {31'b0, w_req}, 32'h1);
        chk("wrap_instret", w_ret, 32'h0);
        chk("wrap_trap", {31'b0, w_trap}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end
endmodule
